// File: rtl/adc_capture_writer_if.sv
// Avalon-MM write-only bus between the ADC capture writer and the SRAM arbiter's adc slave port.
interface adc_capture_writer_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) ();
    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  waitrequest;

    modport master (
        output address,
        output byteenable,
        output write,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  byteenable,
        input  write,
        input  writedata,
        output waitrequest
    );
endinterface

// File: rtl/adc_capture_writer.sv
// ADC capture writer: buffers valid-qualified ADC samples in a small FIFO and
// writes them as an Avalon-MM master to consecutive SRAM word addresses.
module adc_capture_writer #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 16,
    parameter int BE_WIDTH     = DATA_WIDTH / 8,
    parameter int SAMPLE_WIDTH = 12,
    parameter int FIFO_AW      = 3,
    parameter int CNT_WIDTH    = 20
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_WIDTH-1:0]    num_samples,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    adc_capture_writer_if.master    adc,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [CNT_WIDTH-1:0]    words_written
);

    localparam int PTR_W = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [PTR_W-1:0]        w_wptr_nxt;
    logic [PTR_W-1:0]        w_rptr_nxt;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_nonempty_nxt;
    logic [DATA_WIDTH-1:0]   w_push_word;
    logic [DATA_WIDTH-1:0]   w_head_nxt;

    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [CNT_WIDTH-1:0]    r_remaining;
    logic [CNT_WIDTH-1:0]    r_words;
    logic                    r_done;
    logic                    r_overflow;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_clr;
    logic                    w_load;
    logic                    w_done_set;
    logic                    w_ovf_set;

    // Full is decided from the pointers as they stand, before any same-cycle pop.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);

    // Zero-extend the incoming sample to the SRAM word width.
    always_comb begin
        w_push_word = '0;
        w_push_word[SAMPLE_WIDTH-1:0] = sample_data;
    end

    // Next-state and per-cycle control; abort from RUN/FLUSH overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_done_set  = 1'b0;
        w_ovf_set   = 1'b0;
        if ((r_state != IDLE) && abort) begin
            w_state_nxt = IDLE;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_load = 1'b1;
                        w_clr  = 1'b1;
                        if (num_samples == '0) begin
                            w_done_set = 1'b1;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    w_pop = r_write && !adc.waitrequest;
                    if (sample_valid) begin
                        if (w_full) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_push = 1'b1;
                            if (r_remaining == CNT_WIDTH'(1)) begin
                                w_state_nxt = FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    w_pop = r_write && !adc.waitrequest;
                    if (w_empty && !r_write) begin
                        w_state_nxt = IDLE;
                        w_done_set  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Pointer updates and the word that will sit at the FIFO head after this edge;
    // a word being pushed into an otherwise-empty slot is forwarded directly.
    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        if (w_clr) begin
            w_wptr_nxt = '0;
            w_rptr_nxt = '0;
        end else begin
            if (w_push) w_wptr_nxt = r_wptr + PTR_W'(1);
            if (w_pop)  w_rptr_nxt = r_rptr + PTR_W'(1);
        end
        w_nonempty_nxt = (w_wptr_nxt != w_rptr_nxt);
        if (w_rptr_nxt == r_wptr) begin
            w_head_nxt = w_push_word;
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt[FIFO_AW-1:0]];
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= w_push_word;
        end
    end

    // FIFO pointers, registered Avalon outputs, counters and sticky status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_remaining <= '0;
            r_words     <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_write <= w_nonempty_nxt;
            if (w_nonempty_nxt) begin
                r_wdata <= w_head_nxt;
            end
            if (w_load) begin
                r_addr <= base_addr;
            end else if (w_pop) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (w_load) begin
                r_remaining <= num_samples;
            end else if (w_push) begin
                r_remaining <= r_remaining - CNT_WIDTH'(1);
            end
            if (w_load) begin
                r_words <= '0;
            end else if (w_pop) begin
                r_words <= r_words + CNT_WIDTH'(1);
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_load) begin
                r_done <= 1'b0;
            end
            if (w_load) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign adc.address    = r_addr;
    assign adc.byteenable = '1;
    assign adc.write      = r_write;
    assign adc.writedata  = r_wdata;
    assign busy           = (r_state != IDLE);
    assign done           = r_done;
    assign overflow       = r_overflow;
    assign words_written  = r_words;

endmodule

// File: tb/tb_adc_capture_writer.sv
// Self-checking bench for adc_capture_writer: table of directed captures plus
// hand-written stall, overflow, abort/zero-length and asynchronous reset sequences.
module tb_adc_capture_writer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [19:0] base_addr = '0;
    logic [19:0] num_samples = '0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [19:0] words_written;

    adc_capture_writer_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) adc_if ();

    adc_capture_writer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .num_samples   (num_samples),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .adc           (adc_if),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .words_written (words_written)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Captured bus writes (accepted transfers only).
    logic [19:0] cap_addr [64];
    logic [15:0] cap_data [64];
    int          cap_cyc  [64];
    int          cap_cnt = 0;

    always @(negedge clock) begin
        if (adc_if.write && !adc_if.waitrequest && cap_cnt < 64) begin
            cap_addr[cap_cnt] = adc_if.address;
            cap_data[cap_cnt] = adc_if.writedata;
            cap_cyc[cap_cnt]  = cyc;
            cap_cnt = cap_cnt + 1;
        end
    end

    typedef struct packed {
        logic [19:0]      base;
        logic [3:0]       n;
        logic             gap;
        logic [3:0][11:0] smp;
        logic [3:0][19:0] eaddr;
        logic [3:0][15:0] edata;
    } vec_t;

    vec_t vecs [4];

    function automatic vec_t mk(input logic [19:0] base, input logic [3:0] n, input logic gap,
                                input logic [11:0] s0, s1, s2, s3,
                                input logic [19:0] a0, a1, a2, a3,
                                input logic [15:0] d0, d1, d2, d3);
        vec_t v;
        v.base = base; v.n = n; v.gap = gap;
        v.smp[0] = s0; v.smp[1] = s1; v.smp[2] = s2; v.smp[3] = s3;
        v.eaddr[0] = a0; v.eaddr[1] = a1; v.eaddr[2] = a2; v.eaddr[3] = a3;
        v.edata[0] = d0; v.edata[1] = d1; v.edata[2] = d2; v.edata[3] = d3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [19:0] base, input logic [19:0] n);
        @(posedge clock); #1;
        start = 1'b1; base_addr = base; num_samples = n;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic feed_one(input logic [11:0] s);
        sample_valid = 1'b1; sample_data = s;
        @(posedge clock); #1;
        sample_valid = 1'b0;
    endtask

    task automatic feed_seq(input logic [11:0] first, input int count);
        for (int i = 0; i < count; i++) begin
            feed_one(first + 12'(i));
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge clock);
            k = k + 1;
        end
        chk({name, "_done_in_time"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int first_cyc;
        int bad;
        logic [19:0] ref_a;
        logic [15:0] ref_d;
        logic        ref_w;

        vecs[0] = mk(20'h00100, 4'd4, 1'b0, 12'h001, 12'h002, 12'h003, 12'hABC,
                     20'h00100, 20'h00101, 20'h00102, 20'h00103,
                     16'h0001, 16'h0002, 16'h0003, 16'h0ABC);
        vecs[1] = mk(20'hFFFFE, 4'd4, 1'b0, 12'h111, 12'h222, 12'h333, 12'h444,
                     20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001,
                     16'h0111, 16'h0222, 16'h0333, 16'h0444);
        vecs[2] = mk(20'h12345, 4'd3, 1'b1, 12'hFFF, 12'h000, 12'h800, 12'h000,
                     20'h12345, 20'h12346, 20'h12347, 20'h00000,
                     16'h0FFF, 16'h0000, 16'h0800, 16'h0000);
        vecs[3] = mk(20'h00000, 4'd1, 1'b0, 12'h7A5, 12'h000, 12'h000, 12'h000,
                     20'h00000, 20'h00000, 20'h00000, 20'h00000,
                     16'h07A5, 16'h0000, 16'h0000, 16'h0000);
        adc_if.waitrequest = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_write", {31'd0, adc_if.write}, 32'd0);
        chk("rst_address", {12'd0, adc_if.address}, 32'd0);
        chk("rst_writedata", {16'd0, adc_if.writedata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_words", {12'd0, words_written}, 32'd0);
        chk("rst_byteenable", {30'd0, adc_if.byteenable}, 32'h3);
        reset_n = 1'b1;

        // Table-driven captures with free-running arbiter
        for (int v = 0; v < 4; v++) begin
            do_start(vecs[v].base, {16'd0, vecs[v].n});
            cap_cnt = 0;
            first_cyc = cyc;
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                feed_one(vecs[v].smp[i]);
                if (vecs[v].gap) begin
                    @(posedge clock); #1;
                end
            end
            wait_done($sformatf("v%0d", v), 50);
            repeat (2) @(negedge clock);
            chk($sformatf("v%0d_nwrites", v), cap_cnt, {28'd0, vecs[v].n});
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                chk($sformatf("v%0d_addr%0d", v, k), {12'd0, cap_addr[k]}, {12'd0, vecs[v].eaddr[k]});
                chk($sformatf("v%0d_data%0d", v, k), {16'd0, cap_data[k]}, {16'd0, vecs[v].edata[k]});
                if (!vecs[v].gap) begin
                    chk($sformatf("v%0d_cycle%0d", v, k), cap_cyc[k], first_cyc + 1 + k);
                end
            end
            chk($sformatf("v%0d_done", v), {31'd0, done}, 32'd1);
            chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_overflow", v), {31'd0, overflow}, 32'd0);
            chk($sformatf("v%0d_words", v), {12'd0, words_written}, {28'd0, vecs[v].n});
            chk($sformatf("v%0d_write_idle", v), {31'd0, adc_if.write}, 32'd0);
        end

        // Stalled arbiter: outputs frozen while waitrequest is high
        adc_if.waitrequest = 1'b1;
        do_start(20'h00200, 20'd4);
        cap_cnt = 0;
        feed_seq(12'h011, 4);
        @(negedge clock);
        chk("stall_write", {31'd0, adc_if.write}, 32'd1);
        chk("stall_addr", {12'd0, adc_if.address}, 32'h00200);
        chk("stall_data", {16'd0, adc_if.writedata}, 32'h0011);
        ref_a = adc_if.address; ref_d = adc_if.writedata; ref_w = adc_if.write;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (adc_if.address !== ref_a || adc_if.writedata !== ref_d || adc_if.write !== ref_w)
                bad = bad + 1;
        end
        chk("stall_unstable_cycles", bad, 0);
        chk("stall_words", {12'd0, words_written}, 32'd0);
        @(posedge clock); #1;
        adc_if.waitrequest = 1'b0;
        wait_done("stall", 50);
        chk("stall_nwrites", cap_cnt, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_addr%0d", k), {12'd0, cap_addr[k]}, 32'h00200 + k);
            chk($sformatf("stall_data%0d", k), {16'd0, cap_data[k]}, 32'h0011 + k);
        end

        // Overflow: 10 samples into a depth-8 FIFO while stalled
        adc_if.waitrequest = 1'b1;
        do_start(20'h00300, 20'd16);
        cap_cnt = 0;
        feed_seq(12'h0A0, 10);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        adc_if.waitrequest = 1'b0;
        repeat (10) @(negedge clock);
        chk("ovf_first_batch", cap_cnt, 8);
        chk("ovf_first_words", {12'd0, words_written}, 32'd8);
        chk("ovf_still_busy", {31'd0, busy}, 32'd1);
        @(posedge clock); #1;
        feed_seq(12'h0C0, 8);
        wait_done("ovf", 50);
        repeat (2) @(negedge clock);
        chk("ovf_nwrites", cap_cnt, 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ovf_addr%0d", k), {12'd0, cap_addr[k]}, 32'h00300 + k);
            chk($sformatf("ovf_data%0d", k), {16'd0, cap_data[k]},
                (k < 8) ? (32'h00A0 + k) : (32'h00C0 + k - 8));
        end
        chk("ovf_words", {12'd0, words_written}, 32'd16);
        chk("ovf_flag_held", {31'd0, overflow}, 32'd1);

        // Abort while in FLUSH, then zero-length start
        adc_if.waitrequest = 1'b1;
        do_start(20'h00400, 20'd2);
        feed_seq(12'h055, 2);
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        chk("abort_pre_write", {31'd0, adc_if.write}, 32'd1);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort_write", {31'd0, adc_if.write}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_words", {12'd0, words_written}, 32'd0);
        adc_if.waitrequest = 1'b0;
        cap_cnt = 0;
        repeat (3) @(negedge clock);
        chk("abort_done_later", {31'd0, done}, 32'd0);
        chk("abort_no_writes", cap_cnt, 0);
        do_start(20'h00500, 20'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clock);
        chk("zero_no_writes", cap_cnt, 0);
        chk("zero_words", {12'd0, words_written}, 32'd0);

        // Asynchronous reset in the middle of a capture
        do_start(20'h00600, 20'd4);
        feed_seq(12'h123, 2);
        chk("arst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_write", {31'd0, adc_if.write}, 32'd0);
        chk("arst_address", {12'd0, adc_if.address}, 32'd0);
        chk("arst_writedata", {16'd0, adc_if.writedata}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_words", {12'd0, words_written}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_capture_writer.md
Name: adc_capture_writer

Overview:
Avalon-MM write master that captures ADC samples and streams them into SRAM through the arbiter's adc slave port.
- Samples arrive on a valid-qualified stream, pass through a small FIFO, and are written to consecutive word addresses from a programmed base.
- The FIFO absorbs cycles where the arbiter holds waitrequest high because another master is selected.
- Sits between the ADC interface logic and the SRAM arbiter; controlled by the test runner via start/abort and status flags.

Parameters:
ADDR_WIDTH, 20, SRAM word address width
DATA_WIDTH, 16, SRAM data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
SAMPLE_WIDTH, 12, ADC sample width (must be <= DATA_WIDTH)
FIFO_AW, 3, log2 of FIFO depth (depth 8)
CNT_WIDTH, 20, width of sample count / written count

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a capture (honoured only in IDLE)
abort  in  1  terminates any capture
base_addr  in  ADDR_WIDTH  first SRAM word address, latched on start
num_samples  in  CNT_WIDTH  samples to store, latched on start
sample_valid  in  1  sample_data valid this cycle
sample_data  in  SAMPLE_WIDTH  ADC sample
adc_address  out  ADDR_WIDTH  Avalon address
adc_byteenable  out  BE_WIDTH  constant all ones
adc_write  out  1  Avalon write request
adc_writedata  out  DATA_WIDTH  FIFO head, zero-extended
adc_waitrequest  in  1  Avalon waitrequest from arbiter
busy  out  1  high in RUN or FLUSH
done  out  1  sticky, set on normal completion, cleared by start
overflow  out  1  sticky, set when a sample is dropped on a full FIFO, cleared by start
words_written  out  CNT_WIDTH  accepted writes since last start

Behaviour:
Reset: all registered state clears.
- State returns to IDLE; FIFO empty.
- adc_write=0, adc_address=0, adc_writedata=0.
- busy=0, done=0, overflow=0, words_written=0.

States: IDLE, RUN, FLUSH.
- IDLE + start:
  - Latch base_addr into the address counter and num_samples into the remaining counter.
  - Clear FIFO, done, overflow and words_written.
  - Next state RUN, or if num_samples==0, stay IDLE and set done next cycle with no writes.
- RUN, push path:
  - Push occurs when sample_valid=1 and FIFO not full.
  - A push decrements remaining; the pushed word is {zeros, sample_data}.
  - Full is evaluated before any same-cycle pop. If full and sample_valid=1, the sample is dropped, overflow<=1, and remaining is unchanged (dropped samples are not counted).
  - When remaining reaches 0 after a push, go to FLUSH; further sample_valid is ignored.
- FLUSH: no pushes. Go to IDLE with done<=1 once the FIFO is empty and no write is pending.
- abort in RUN/FLUSH, which has priority over start and all transfers:
  - Next cycle: IDLE, adc_write=0, FIFO emptied.
  - done stays 0; overflow and words_written are held.
- abort in IDLE: no effect.

Write path (registered outputs):
- adc_write is asserted the cycle after the FIFO becomes non-empty. Minimum latency is sample_valid at cycle N to adc_write=1 at N+1.
- A transfer completes on a cycle with adc_write=1 and adc_waitrequest=0. On that edge:
  - FIFO pops; adc_address increments by 1 and wraps modulo 2^ADDR_WIDTH; words_written increments.
  - The next head is presented with adc_write held high if the FIFO is still non-empty.
  - Back-to-back writes are one per cycle.
- While adc_waitrequest=1: adc_address, adc_writedata and adc_write are held stable.
- FIFO: circular buffer with FIFO_AW+1-bit read/write pointers; full and empty are derived from the pointers.
- busy = (state != IDLE).

Test Plan:
- Back-to-back capture:
  - Stimulus: base_addr=0x00100, num_samples=4, waitrequest=0, samples 0x001,0x002,0x003,0xABC on consecutive cycles.
  - Required: writes to 0x00100..0x00103 with data 0x0001,0x0002,0x0003,0x0ABC, one per cycle; done=1; words_written=4; overflow=0.
- Stalled arbiter:
  - Stimulus: waitrequest=1 for 20 cycles during a 4-sample capture.
  - Required: adc_address/adc_writedata/adc_write stable throughout; all 4 writes complete after release; addresses contiguous.
- Overflow:
  - Stimulus: depth 8, waitrequest=1, 10 samples valid on consecutive cycles, num_samples=16.
  - Required: samples 9 and 10 dropped; overflow=1; after release, 8 writes occur and capture continues until 16 samples stored.
- Address wrap:
  - Stimulus: base_addr=0xFFFFE, num_samples=4.
  - Required: writes to 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Abort and zero length:
  - Abort mid-FLUSH: adc_write=0 next cycle, busy=0, done=0.
  - Then start with num_samples=0: no writes, done=1 one cycle later.
  - Asserting reset_n=0 mid-RUN: all outputs are 0 immediately, without waiting for a clock edge.
